avg8_pwm: RTL and testbench
===========================

# avg8_pwm

Motor-speed support block: an 8-sample moving-average filter on a strobed 8-bit tachometer count, plus an independent 8-bit PWM generator. Both run on one clock. The surrounding speed controller feeds encoder pulse counts into the averager and drives the PWM duty from its rate computation.

## Interface
- Parameters:
  - `W`, default 8: sample and duty width (fixed at 8; not retargetable).
  - `N_LOG2`, default 3: log2 of the averaging depth (fixed at 3, depth 8).
- Ports:
  - `CLK`, in, 1 bit: single clock, rising edge.
  - `RST_N`, in, 1 bit: reset, asynchronous, active-low.
  - `SAMPLE_STB`, in, 1 bit: one-cycle strobe; captures `SAMPLE_IN`.
  - `SAMPLE_IN`, in, 8 bits: new sample (pulse count).
  - `AVERAGE_OUT`, out, 8 bits: mean of the last 8 captured samples.
  - `DUTY_CYCLE`, in, 8 bits: requested PWM high time, in clocks per 256-clock period.
  - `PWM_OUT`, out, 1 bit: registered PWM waveform.

## Operation
- Averager:
  - 8-entry sample shift register `hist[0..7]` and an 11-bit running sum.
  - On a cycle with `SAMPLE_STB`=1:
    - `sum <= sum + SAMPLE_IN - hist[7]`.
    - History shifts by one and `hist[0] <= SAMPLE_IN`.
  - Cycles with `SAMPLE_STB`=0 change nothing.
  - `AVERAGE_OUT = sum[10:3]`, truncating (floor), driven directly from the sum register.
  - Sum never overflows: max is 8×255 = 2040 < 2048.
  - Back-to-back strobes on consecutive cycles are legal; each one captures a sample.
- PWM:
  - Free-running 8-bit counter `cnt` increments every cycle and wraps 255→0, giving a 256-clock period.
  - `PWM_OUT <= (cnt < duty_eff)`.
  - `duty_eff` = 0 gives constant low; 255 gives high for 255 of 256 clocks. 100% duty is not reachable.
  - The high time per period is exactly `duty_eff` clocks, starting at `cnt`=0.

## Timing
- Reset (async assert, synchronous-style deassert):
  - `hist`, `sum` and `cnt` all clear to 0.
  - `AVERAGE_OUT`=0 and `PWM_OUT`=0.
  - `duty_eff`=0.
- Averager latency: `AVERAGE_OUT` reflects a sample from the rising edge that captured it, with 0 extra cycles.
- PWM latency: `PWM_OUT` is registered, so it lags the counter compare by 1 clock.
- First clock after reset release: `cnt`=0 and `PWM_OUT`=0. On the next edge `PWM_OUT` becomes 1 if `duty_eff`>0.
- Reset mid-operation: every state is lost immediately. The average restarts from an all-zero history, so the first post-reset sample S yields floor(S/8).

## Configuration
- `AVG8_PWM_DUTY_SYNC_EN`:
  - Defined: `duty_eff` is a register loaded from `DUTY_CYCLE` only on the cycle where `cnt`=255. A duty change takes effect at the next period boundary, so there are no glitch or partial periods.
  - Undefined: `duty_eff = DUTY_CYCLE` combinationally. A mid-period change takes effect on the next compare.
  - Reset value is 0 in both builds.

## Structure
- Shared package `avg8_pwm_pkg`:
  - `SAMPLE_W`=8 and `SUM_W`=11.
  - `PWM_PERIOD`=256.
  - Typedef `sample_t` (8-bit).
- Top `avg8_pwm` instantiates one natural sub-module, `pwm8_gen`, containing the counter, the duty-sync logic and the output register.
- The averager stays inline in the top.

## Test plan
- Reset → `AVERAGE_OUT`=0 and `PWM_OUT`=0 while `RST_N`=0. Assert `RST_N` mid-period → both outputs go to 0 immediately, without waiting for a clock.
- Step input: 8 strobes of 80 after reset → `AVERAGE_OUT` = 10, 20, …, 80. Further strobes of 80 → `AVERAGE_OUT` holds at 80.
- Truncation and wrap: 8 strobes of 255 → 255. Then one strobe of 0 → floor(1785/8) = 223. Holding `SAMPLE_STB` low for 100 cycles → `AVERAGE_OUT` unchanged.
- PWM duty sweep, high clocks counted per 256-clock period:
  - `DUTY_CYCLE`=0 → 0.
  - 128 → 128, contiguous from the period start.
  - 255 → 255.
  - 1 → exactly 1.
- Mid-period duty change from 64 to 192 at `cnt`=100:
  - With `AVG8_PWM_DUTY_SYNC_EN`: the current period has 64 high clocks and the next has 192.
  - Without it: the current period's output goes high again from `cnt`=100 through 191.
- Simultaneous events: strobes every cycle while PWM runs → the averager and PWM stay independent, and PWM counts match the sweep results.

Source files
------------

// File: rtl/avg8_pwm_pkg.sv
// avg8_pwm_pkg: shared widths and types for the tachometer averager and the PWM generator.
package avg8_pwm_pkg;

    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned SUM_W      = 11;
    localparam int unsigned PWM_PERIOD = 256;
    localparam int unsigned HIST_DEPTH = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SUM_W-1:0]    sum_t;

endpackage

// File: rtl/pwm8_gen.sv
// pwm8_gen: free-running 8-bit PWM with a registered output.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   duty_i : requested high time in clocks per 256-clock period
//   pwm_o  : PWM waveform, high for duty_eff clocks from the period start
// Build option AVG8_PWM_DUTY_SYNC_EN: when defined, duty_i is sampled only when
// the counter is at 255, so a duty change lands on the next period boundary.
module pwm8_gen
    import avg8_pwm_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  sample_t duty_i,
    output logic    pwm_o
);

    sample_t cnt_q, cnt_d;
    logic    pwm_q, pwm_d;
    sample_t duty_eff;

`ifdef AVG8_PWM_DUTY_SYNC_EN
    localparam sample_t CNT_MAX = SAMPLE_W'(PWM_PERIOD - 1);

    sample_t duty_eff_q, duty_eff_d;

    // Duty reload only at the last count so every period is whole.
    always_comb begin
        duty_eff_d = duty_eff_q;
        if (cnt_q == CNT_MAX) begin
            duty_eff_d = duty_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_eff_q <= '0;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end

    assign duty_eff = duty_eff_q;
`else
    assign duty_eff = duty_i;
`endif

    // Counter wraps naturally at 255 -> 0; the compare is registered.
    always_comb begin
        cnt_d = cnt_q + SAMPLE_W'(1);
        pwm_d = (cnt_q < duty_eff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/avg8_pwm.sv
// avg8_pwm: 8-sample moving average of a strobed tachometer count plus an
// independent 8-bit PWM generator on the same clock.
//   CLK         : clock, rising edge
//   RST_N       : asynchronous active-low reset
//   SAMPLE_STB  : one-cycle strobe capturing SAMPLE_IN
//   SAMPLE_IN   : new sample (pulse count)
//   AVERAGE_OUT : floor of the mean of the last 8 captured samples
//   DUTY_CYCLE  : PWM high time in clocks per 256-clock period
//   PWM_OUT     : registered PWM waveform
// Build option AVG8_PWM_DUTY_SYNC_EN selects period-boundary duty updates (see pwm8_gen).
module avg8_pwm
    import avg8_pwm_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned N_LOG2 = 3
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         SAMPLE_STB,
    input  logic [W-1:0] SAMPLE_IN,
    output logic [W-1:0] AVERAGE_OUT,
    input  logic [W-1:0] DUTY_CYCLE,
    output logic         PWM_OUT
);

    sample_t hist_q [HIST_DEPTH];
    sample_t hist_d [HIST_DEPTH];
    sum_t    sum_q, sum_d;

    // Running sum: add the new sample, drop the one falling off the end.
    // The result is never negative and never exceeds 8*255, so 11 bits suffice.
    always_comb begin
        sum_d = sum_q;
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (SAMPLE_STB) begin
            sum_d     = sum_q + SUM_W'(SAMPLE_IN) - SUM_W'(hist_q[HIST_DEPTH-1]);
            hist_d[0] = sample_t'(SAMPLE_IN);
            for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q <= '0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            sum_q <= sum_d;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    // Divide by 8 is a plain bit slice of the registered sum (floor).
    assign AVERAGE_OUT = sum_q[N_LOG2 +: W];

    pwm8_gen u_pwm (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .duty_i (sample_t'(DUTY_CYCLE)),
        .pwm_o  (PWM_OUT)
    );

endmodule

// File: tb/tb_avg8_pwm.sv
module tb_avg8_pwm;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       SAMPLE_STB;
    logic [7:0] SAMPLE_IN;
    logic [7:0] AVERAGE_OUT;
    logic [7:0] DUTY_CYCLE;
    logic       PWM_OUT;

    int errors = 0;
    int checks = 0;

    int exp_q[$];
    logic cap;
    logic [7:0] m_cnt;

    avg8_pwm dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SAMPLE_STB  (SAMPLE_STB),
        .SAMPLE_IN   (SAMPLE_IN),
        .AVERAGE_OUT (AVERAGE_OUT),
        .DUTY_CYCLE  (DUTY_CYCLE),
        .PWM_OUT     (PWM_OUT)
    );

    always #5 CLK = ~CLK;

    // Reference time base: period position of the counter, independent of the DUT.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_cnt <= 8'd0;
        else        m_cnt <= m_cnt + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every captured strobe must produce the queued average.
    initial begin
        forever begin
            @(posedge CLK);
            cap = SAMPLE_STB && RST_N;
            @(negedge CLK);
            if (cap) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL avg_unexpected: got %0d with no expected value queued", AVERAGE_OUT);
                end else begin
                    check("avg", 32'(AVERAGE_OUT), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic strobe(input int v, input int e);
        SAMPLE_IN  = 8'(v);
        SAMPLE_STB = 1'b1;
        exp_q.push_back(e);
        @(negedge CLK);
        SAMPLE_STB = 1'b0;
    endtask

    // Wait for the negedge at which PWM_OUT shows period position 0.
    task automatic align(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (m_cnt == 8'd1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_align_timeout"}, 0, 1);
    endtask

    task automatic run_window(input int duty, input string name);
        bit ok;
        int hi;
        int bad;
        hi = 0;
        bad = 0;
        align(name, ok);
        if (ok) begin
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge CLK);
                if (PWM_OUT === 1'b1) hi++;
                if (PWM_OUT !== ((i < duty) ? 1'b1 : 1'b0)) bad++;
            end
            check({name, "_high_count"}, 32'(hi), 32'(duty));
            check({name, "_shape_errs"}, 32'(bad), 0);
        end
    endtask

    task automatic mid_change();
        bit ok;
        int hi1, hi2, bad;
        logic e;
        hi1 = 0; hi2 = 0; bad = 0;
        align("midchg", ok);
        if (ok) begin
            for (int i = 0; i < 512; i++) begin
                if (i > 0) @(negedge CLK);
                if (i < 256) begin
`ifdef AVG8_PWM_DUTY_SYNC_EN
                    e = (i < 64);
`else
                    e = (i < 64) || (i >= 100 && i < 192);
`endif
                    if (PWM_OUT === 1'b1) hi1++;
                end else begin
                    e = ((i - 256) < 192);
                    if (PWM_OUT === 1'b1) hi2++;
                end
                if (PWM_OUT !== e) bad++;
                // Next compare uses cnt = 100.
                if (i == 99) DUTY_CYCLE = 8'd192;
            end
`ifdef AVG8_PWM_DUTY_SYNC_EN
            check("midchg_period1", 32'(hi1), 64);
`else
            check("midchg_period1", 32'(hi1), 156);
`endif
            check("midchg_period2", 32'(hi2), 192);
            check("midchg_shape_errs", 32'(bad), 0);
        end
    endtask

    initial begin
        bit ok;
        RST_N      = 1'b0;
        SAMPLE_STB = 1'b0;
        SAMPLE_IN  = 8'd0;
        DUTY_CYCLE = 8'd0;
        repeat (3) @(negedge CLK);
        check("reset_avg", 32'(AVERAGE_OUT), 0);
        check("reset_pwm", 32'(PWM_OUT), 0);
        RST_N = 1'b1;
        DUTY_CYCLE = 8'd128;
        @(negedge CLK);
        check("first_clk_pwm", 32'(PWM_OUT), 1);

        // Step input of 80.
        for (int k = 1; k <= 8; k++) strobe(80, 10 * k);
        strobe(80, 80);
        strobe(80, 80);

        // Async reset mid-period while PWM is high and the average is nonzero.
        repeat (300) @(negedge CLK);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (m_cnt == 8'd50) break;
        end
        check("pre_reset_pwm", 32'(PWM_OUT), 1);
        check("pre_reset_avg", 32'(AVERAGE_OUT), 80);
        #2 RST_N = 1'b0;
        #1;
        check("async_reset_avg", 32'(AVERAGE_OUT), 0);
        check("async_reset_pwm", 32'(PWM_OUT), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        strobe(200, 25);

        // Clean reset, then saturation and truncation.
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        strobe(255, 31);
        strobe(255, 63);
        strobe(255, 95);
        strobe(255, 127);
        strobe(255, 159);
        strobe(255, 191);
        strobe(255, 223);
        strobe(255, 255);
        strobe(0, 223);
        repeat (100) @(negedge CLK);
        check("hold_avg", 32'(AVERAGE_OUT), 223);

        // Duty sweep; the settle delay covers a period-boundary reload.
        DUTY_CYCLE = 8'd0;   repeat (300) @(negedge CLK); run_window(0,   "duty0");
        DUTY_CYCLE = 8'd128; repeat (300) @(negedge CLK); run_window(128, "duty128");
        DUTY_CYCLE = 8'd255; repeat (300) @(negedge CLK); run_window(255, "duty255");
        DUTY_CYCLE = 8'd1;   repeat (300) @(negedge CLK); run_window(1,   "duty1");

        // Mid-period change 64 -> 192 at cnt = 100.
        DUTY_CYCLE = 8'd64;  repeat (300) @(negedge CLK);
        mid_change();

        // Back-to-back strobes while a PWM period is measured.
        DUTY_CYCLE = 8'd128; repeat (300) @(negedge CLK);
        fork
            run_window(128, "concurrent");
            begin
                repeat (20) @(negedge CLK);
                strobe(16, 193); strobe(16, 163); strobe(16, 133); strobe(16, 103);
                strobe(16, 73);  strobe(16, 43);  strobe(16, 14);  strobe(16, 16);
                strobe(0, 14);   strobe(0, 12);   strobe(0, 10);   strobe(0, 8);
                strobe(0, 6);    strobe(0, 4);    strobe(0, 2);    strobe(0, 0);
            end
        join
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
